// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the regfile's single write port between the pipeline writeback
//   stage and the multiply/divide unit. Multdiv results wait in a 2-entry
//   FIFO and drain into cycles the pipeline leaves free; a head entry that
//   waits STARVE_LIMIT cycles forces a one-cycle pipeline stall.
// Ports
//   clock, reset                  rising-edge clock, sync active-high reset
//   wb_valid/wb_addr/wb_data      pipeline writeback request (no backpressure)
//   md_valid/md_addr/md_data      multdiv result, md_ready accepts it
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg   registered write port
//   stall_pipe                    pipeline must not write this cycle
//   pending_mask                  one-hot OR of queued destination regs
//   protocol_err                  sticky: wb_valid seen during stall_pipe
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        ctrl_writeEnable,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        stall_pipe,
    output logic [31:0] pending_mask,
    output logic        protocol_err
);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    // Entry 0 is always the head; entry 1 shifts down on dequeue.
    logic [1:0]  count;
    logic [4:0]  q_addr [2];
    logic [31:0] q_data [2];
    logic [3:0]  starve_cnt;

    logic wb_grant, deq, enq;
    logic [1:0] slot;

    assign stall_pipe = (starve_cnt == LIM);
    assign md_ready   = (count != 2'd2);
    assign wb_grant   = !stall_pipe && wb_valid && (wb_addr != 5'd0);
    // stall_pipe implies count != 0, so a stall always dequeues.
    assign deq        = (count != 2'd0) && !wb_grant;
    assign enq        = md_valid && md_ready && (md_addr != 5'd0);
    // Slot the new entry lands in once this cycle's dequeue has shifted.
    assign slot       = count - 2'(deq);

    always_comb begin
        pending_mask = '0;
        if (count != 2'd0) pending_mask[q_addr[0]] = 1'b1;
        if (count == 2'd2) pending_mask[q_addr[1]] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count            <= 2'd0;
            starve_cnt       <= 4'd0;
            ctrl_writeEnable <= 1'b0;
            ctrl_writeReg    <= 5'd0;
            data_writeReg    <= 32'd0;
            protocol_err     <= 1'b0;
        end else begin
            ctrl_writeEnable <= wb_grant || deq;
            if (wb_grant) begin
                ctrl_writeReg <= wb_addr;
                data_writeReg <= wb_data;
            end else if (deq) begin
                ctrl_writeReg <= q_addr[0];
                data_writeReg <= q_data[0];
            end
            count <= count + 2'(enq) - 2'(deq);
            if (deq || count == 2'd0)
                starve_cnt <= 4'd0;
            else if (!stall_pipe)
                starve_cnt <= starve_cnt + 4'd1;
            if (wb_valid && stall_pipe)
                protocol_err <= 1'b1;
        end
    end

    // Payload storage needs no reset: validity comes from count.
    always_ff @(posedge clock) begin
        if (deq) begin
            q_addr[0] <= q_addr[1];
            q_data[0] <= q_data[1];
        end
        if (enq) begin
            if (slot == 2'd0) begin
                q_addr[0] <= md_addr;
                q_data[0] <= md_data;
            end else begin
                q_addr[1] <= md_addr;
                q_data[1] <= md_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: the stimulus task runs a queue-based reference model and
// pushes each predicted write; a negedge monitor pops and compares whenever
// the DUT presents a write, and checks status outputs against model state.
module tb_regfile_write_arbiter;
    localparam int LIM = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid = 1'b0, md_valid = 1'b0;
    logic [4:0]  wb_addr = '0, md_addr = '0;
    logic [31:0] wb_data = '0, md_data = '0;
    logic        md_ready, ctrl_writeEnable, stall_pipe, protocol_err;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg, pending_mask;

    regfile_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
        .md_ready(md_ready), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .stall_pipe(stall_pipe), .pending_mask(pending_mask),
        .protocol_err(protocol_err)
    );

    always #5 clock = ~clock;

    // Reference model state
    wr_t         mq[$];     // queued multdiv results, head first
    wr_t         expq[$];   // predicted write-port writes
    int          age;       // cycles the queue has gone without a dequeue
    bit          mperr;
    logic [4:0]  mreg;
    logic [31:0] mdat;
    bit          chk_en = 0;
    int          nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit wbv, input logic [4:0] wba,
                       input logic [31:0] wbd, input bit mdv,
                       input logic [4:0] mda, input logic [31:0] mdd);
        bit stall, popped;
        int sz;
        wr_t w;
        @(negedge clock); #1;
        reset = r; wb_valid = wbv; wb_addr = wba; wb_data = wbd;
        md_valid = mdv; md_addr = mda; md_data = mdd;
        if (r) begin
            mq.delete(); expq.delete();
            age = 0; mperr = 0; mreg = '0; mdat = '0;
        end else begin
            stall  = (age == LIM);
            sz     = mq.size();
            popped = 0;
            if (stall && wbv) mperr = 1;
            if (!stall && wbv && wba != 0) begin
                w = '{a: wba, d: wbd};
                expq.push_back(w); mreg = wba; mdat = wbd;
            end else if (sz != 0) begin
                w = mq.pop_front();
                expq.push_back(w); mreg = w.a; mdat = w.d;
                popped = 1;
            end
            if (popped || sz == 0) age = 0;
            else if (age < LIM) age++;
            if (mdv && sz != 2 && mda != 0) mq.push_back('{a: mda, d: mdd});
        end
        chk_en = 1;
    endtask

    always @(negedge clock) begin
        logic [31:0] em;
        wr_t w;
        if (chk_en) begin
            em = '0;
            foreach (mq[i]) em[mq[i].a] = 1'b1;
            if (ctrl_writeEnable) begin
                if (expq.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL spurious_write: got r%0d=%h expected none at %0t",
                             ctrl_writeReg, data_writeReg, $time);
                end else begin
                    w = expq.pop_front();
                    chk("write_reg", 32'(ctrl_writeReg), 32'(w.a));
                    chk("write_data", data_writeReg, w.d);
                end
            end else if (expq.size() != 0) begin
                w = expq.pop_front();
                nvec++; nerr++;
                $display("FAIL missing_write: got none expected r%0d=%h at %0t",
                         w.a, w.d, $time);
            end
            chk("held_reg", 32'(ctrl_writeReg), 32'(mreg));
            chk("held_data", data_writeReg, mdat);
            chk("stall_pipe", 32'(stall_pipe), 32'(age == LIM));
            chk("md_ready", 32'(md_ready), 32'(mq.size() != 2));
            chk("pending_mask", pending_mask, em);
            chk("protocol_err", 32'(protocol_err), 32'(mperr));
        end
    end

    initial begin
        int stalls;
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        // pipeline only
        cyc(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        cyc(0, 1, 0, 32'h11111111, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        // idle drain
        cyc(0, 0, 0, 0, 1, 9, 32'h12345678);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        // full queue under continuous wb, third result held off
        cyc(0, 1, 1, $urandom, 1, 3, 32'h33333333);
        cyc(0, 1, 2, $urandom, 1, 4, 32'h44444444);
        for (int i = 0; i < 8; i++) cyc(0, 1, 5'(10 + i), $urandom, 1, 5, 32'h55555555);
        repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
        // starvation then protocol error: wb r7 during the stall
        cyc(0, 0, 0, 0, 1, 9, 32'h99999999);
        stalls = 0;
        while (age != LIM && stalls < 10) begin
            cyc(0, 1, 1, $urandom, 0, 0, 0);
            stalls++;
        end
        chk("starve_delay", 32'(stalls), 32'(LIM));
        cyc(0, 1, 7, 32'h77777777, 0, 0, 0);
        repeat (5) cyc(0, 1, 2, $urandom, 0, 0, 0);
        // reset flush with two entries queued
        cyc(0, 1, 1, $urandom, 1, 20, $urandom);
        cyc(0, 1, 1, $urandom, 1, 21, $urandom);
        cyc(1, 1, 1, $urandom, 1, 22, $urandom);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, wv;
            r  = ($urandom_range(0, 199) == 0);
            wv = (age == LIM) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
            cyc(r, wv, 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        end
        repeat (6) cyc(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); #2;
        chk("drain", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the in-order pipeline writeback stage and the multiply/divide unit. Multdiv results are buffered in a 2-entry queue and drained into free write-port cycles, with a bounded-starvation stall request to the pipeline. The block drives the write address/enable that feed the regfile's 5-to-32 write decoder. It also exports a one-hot mask of registers with queued results, produced by an internal 5-to-32 decode, for the pipeline hazard logic.

## Interface
- STARVE_LIMIT, 4, cycles a queued multdiv result may wait before a forced pipeline stall (legal range 1–15)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  pipeline writeback request this cycle (no backpressure)
- wb_addr  in  5  pipeline destination register
- wb_data  in  32  pipeline write data
- md_valid  in  1  multdiv result valid
- md_addr  in  5  multdiv destination register
- md_data  in  32  multdiv result
- md_ready  out  1  queue can accept a multdiv result
- ctrl_writeEnable  out  1  regfile write enable (to decoder enable)
- ctrl_writeReg  out  5  regfile write address (to decoder input)
- data_writeReg  out  32  regfile write data
- stall_pipe  out  1  pipeline must present wb_valid=0 this cycle
- pending_mask  out  32  bit i set if any queued entry targets register i
- protocol_err  out  1  sticky: wb_valid seen while stall_pipe high

## Operation
- Queue: 2-entry FIFO of {addr, data}, count 0..2. md_ready = (count != 2), decoded from registered state only.
- Enqueue when md_valid && md_ready && md_addr != 0. Results with md_addr == 0 are accepted (handshake completes) and discarded.
- Grant priority, evaluated every cycle:
  - If stall_pipe: dequeue the queue head.
  - Else if wb_valid && wb_addr != 0: grant wb.
  - Else if count != 0: dequeue the queue head.
  - Else: no write.
- wb_valid with wb_addr == 0 writes nothing and leaves the port free for the queue that cycle.
- Simultaneous enqueue and dequeue at count 1: count stays 1; the new entry becomes head next cycle.
- An enqueued value is never dequeued in the same cycle it arrives; there is no bypass.
- Starvation counter starve_cnt:
  - Resets to 0 on any dequeue or when count == 0.
  - Otherwise increments, saturating at STARVE_LIMIT.
- stall_pipe = (starve_cnt == STARVE_LIMIT), decoded from the register. Because the head is dequeued in that cycle, stall_pipe is high for exactly one cycle per starvation event.
- wb_valid while stall_pipe is high: the wb request is ignored (not written) and protocol_err is set.
- pending_mask: per-entry 5-to-32 decode of each valid entry's addr, gated by that entry's valid bit, ORed together. Derived from registered state.
- Pipeline contract: never issue wb_addr with pending_mask[wb_addr] set. Violations are not detected.

## Timing
- Reset values:
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - stall_pipe=0, protocol_err=0, md_ready=1, pending_mask=0.
  - Queue empty, starve_cnt=0.
  - Reset asserted mid-operation flushes queued entries without writing them.
- Write-port outputs are registered. A grant decided from inputs sampled at edge N appears as ctrl_writeEnable/ctrl_writeReg/data_writeReg during cycle N..N+1.
- Write-port outputs hold their previous addr/data when ctrl_writeEnable=0.
- Multdiv latency: accepted at edge N; earliest write-port output is after edge N+1 (2 cycles).
- pending_mask bit clears on the edge where the entry is dequeued, coincident with its ctrl_writeEnable going high.
- Back-to-back writes are sustained with no bubbles: one write per cycle.

## Test plan
- Pipeline only: after reset, wb_valid with wb_addr=5, wb_data=0xDEADBEEF -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF. wb_addr=0 -> ctrl_writeEnable=0.
- Idle drain: md_valid with md_addr=9, md_data=0x12345678, wb idle -> pending_mask=0x200 one cycle later, then the r9 write on the following cycle and pending_mask returns to 0.
- Full queue: two md results (r3, r4) enqueued while wb writes every cycle -> md_ready=0, pending_mask=0x18. A third md_valid is held off until a slot frees.
- Starvation, STARVE_LIMIT=4: one queued result plus continuous wb writes -> stall_pipe high for exactly one cycle, 4 cycles after the enqueue cycle. The queued write issues after that edge.
- Protocol error: drive wb_valid=1, wb_addr=7 during stall_pipe -> no r7 write, protocol_err=1 and stays 1 until reset.
- Reset flush: reset with 2 entries queued -> no writes issue, md_ready=1, pending_mask=0 after the reset edge.
